// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker.
// Consumes majority-voted bit samples (one strobe per bit time), assembles an
// LSB-first data word, checks optional parity and the stop bit(s), and reports
// good frames, start glitches and framing/parity errors as one-cycle pulses.
// A saturating counter tallies errored frames and rejected start bits.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a start-bit strobe (0 = start, 1 = glitch)
// DATA   | shifting in DATA_WIDTH data bits, LSB first
// PARITY | checking the parity bit against the received data
// STOP   | consuming STOP_BITS stop strobes, recording any sampled 0
module uart_rx_frame_check #(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  sampled_bit,
  input  logic                  bit_valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  strt_glitch,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy,
  output logic [ERR_CNT_W-1:0]  err_cnt
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    stop_cnt;
  logic [DATA_WIDTH-1:0]   shift;
  logic                    par_en_lat;
  logic                    par_typ_lat;
  logic                    par_fail;
  logic                    stp_fail;

  logic                    last_data;
  logic                    last_stop;
  logic                    par_mismatch;

  logic                    dv_d;
  logic                    glitch_d;
  logic                    par_err_d;
  logic                    stp_err_d;
  logic                    busy_d;
  logic                    err_inc;

  assign last_data    = (bit_cnt == CNT_W'(DATA_WIDTH - 1));
  assign last_stop    = (stop_cnt == 1'(STOP_BITS - 1));
  // Even parity expects XOR of the data; odd parity expects its inverse.
  assign par_mismatch = sampled_bit ^ ((^shift) ^ par_typ_lat);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode; nothing advances without a bit strobe.
  always_comb begin
    state_nxt = state;
    if (bit_valid) begin
      case (state)
        IDLE:    if (!sampled_bit) state_nxt = DATA;
        DATA:    if (last_data) state_nxt = par_en_lat ? PARITY : STOP;
        PARITY:  state_nxt = STOP;
        STOP:    if (last_stop) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode: next values of the registered outputs.
  always_comb begin
    dv_d      = 1'b0;
    glitch_d  = 1'b0;
    par_err_d = 1'b0;
    stp_err_d = 1'b0;
    if (bit_valid && state == IDLE && sampled_bit) glitch_d = 1'b1;
    if (bit_valid && state == STOP && last_stop) begin
      // The final stop sample is folded in here, it is not yet in stp_fail.
      par_err_d = par_fail;
      stp_err_d = stp_fail | ~sampled_bit;
      dv_d      = ~par_fail & sampled_bit & ~stp_fail;
    end
    busy_d  = (state_nxt != IDLE);
    // Parity and stop failures in one frame count as a single error.
    err_inc = glitch_d | par_err_d | stp_err_d;
  end

  // Frame datapath: config latch, bit counting, shifting and fail flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      shift       <= '0;
      par_en_lat  <= 1'b0;
      par_typ_lat <= 1'b0;
      par_fail    <= 1'b0;
      stp_fail    <= 1'b0;
    end else if (bit_valid) begin
      case (state)
        IDLE: begin
          if (!sampled_bit) begin
            par_en_lat  <= PAR_EN;
            par_typ_lat <= PAR_TYP;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            par_fail    <= 1'b0;
            stp_fail    <= 1'b0;
          end
        end
        DATA: begin
          shift   <= {sampled_bit, shift[DATA_WIDTH-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        PARITY: begin
          if (par_mismatch) par_fail <= 1'b1;
        end
        STOP: begin
          if (!sampled_bit) stp_fail <= 1'b1;
          stop_cnt <= stop_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: pulses, busy, last good word and error counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
      busy        <= 1'b0;
      err_cnt     <= '0;
    end else begin
      data_valid  <= dv_d;
      strt_glitch <= glitch_d;
      par_err     <= par_err_d;
      stp_err     <= stp_err_d;
      busy        <= busy_d;
      if (dv_d) P_DATA <= shift;
      if (err_clr)                         err_cnt <= '0;
      else if (err_inc && err_cnt != '1)   err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: one 8-bit/1-stop instance and one
// 8-bit/2-stop instance. Stimulus pushes hand-computed expected pulses into a
// per-instance queue; monitors pop and compare whenever a pulse appears.
module tb_uart_rx_frame_check;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic       sg;
    logic [7:0] pd;
    int         cyc;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic sb0 = 1'b0, bv0 = 1'b0, sb1 = 1'b0, bv1 = 1'b0;
  logic PAR_EN = 1'b0, PAR_TYP = 1'b0, err_clr = 1'b0;

  logic [7:0] pd0, pd1;
  logic dv0, sg0, pe0, se0, busy0;
  logic dv1, sg1, pe1, se1, busy1;
  logic [7:0] ec0, ec1;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(1), .ERR_CNT_W(8)) dut0 (
    .CLK(CLK), .RST(RST), .sampled_bit(sb0), .bit_valid(bv0),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .err_clr(err_clr),
    .P_DATA(pd0), .data_valid(dv0), .strt_glitch(sg0), .par_err(pe0),
    .stp_err(se0), .busy(busy0), .err_cnt(ec0)
  );

  uart_rx_frame_check #(.DATA_WIDTH(8), .STOP_BITS(2), .ERR_CNT_W(8)) dut1 (
    .CLK(CLK), .RST(RST), .sampled_bit(sb1), .bit_valid(bv1),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .err_clr(err_clr),
    .P_DATA(pd1), .data_valid(dv1), .strt_glitch(sg1), .par_err(pe1),
    .stp_err(se1), .busy(busy1), .err_cnt(ec1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic dv, input logic pe, input logic se,
                              input logic sg, input logic [7:0] pd);
    exp_t e;
    e.dv = dv; e.pe = pe; e.se = se; e.sg = sg; e.pd = pd; e.cyc = 0;
    return e;
  endfunction

  task automatic mon(input int w, input logic dv, input logic pe, input logic se,
                     input logic sg, input logic [7:0] pd);
    exp_t e;
    if ((w == 0 && q0.size() == 0) || (w == 1 && q1.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_pulse dut%0d actual dv=%b pe=%b se=%b sg=%b required none",
               w, dv, pe, se, sg);
    end else begin
      e = (w == 0) ? q0.pop_front() : q1.pop_front();
      chk($sformatf("dut%0d data_valid", w), 32'(dv), 32'(e.dv));
      chk($sformatf("dut%0d par_err", w), 32'(pe), 32'(e.pe));
      chk($sformatf("dut%0d stp_err", w), 32'(se), 32'(e.se));
      chk($sformatf("dut%0d strt_glitch", w), 32'(sg), 32'(e.sg));
      chk($sformatf("dut%0d P_DATA", w), 32'(pd), 32'(e.pd));
      chk($sformatf("dut%0d latency_cycle", w), 32'(cyc), 32'(e.cyc));
    end
  endtask

  // Monitors: sample away from the rising edge.
  always @(negedge CLK) if (!RST && (dv0 | pe0 | se0 | sg0)) mon(0, dv0, pe0, se0, sg0, pd0);
  always @(negedge CLK) if (!RST && (dv1 | pe1 | se1 | sg1)) mon(1, dv1, pe1, se1, sg1, pd1);

  // One strobe followed by one idle cycle; push arms the expectation first.
  task automatic send_bit(input int w, input logic b, input logic push, input exp_t e);
    exp_t x;
    x = e;
    @(negedge CLK);
    if (push) begin
      x.cyc = cyc + 1;
      if (w == 0) q0.push_back(x);
      else        q1.push_back(x);
    end
    if (w == 0) begin sb0 = b; bv0 = 1'b1; end
    else        begin sb1 = b; bv1 = 1'b1; end
    @(negedge CLK);
    bv0 = 1'b0;
    bv1 = 1'b0;
  endtask

  task automatic frame(input int w, input logic [7:0] d, input logic pen, input logic pbit,
                       input logic s1, input logic s2, input int nstop, input exp_t e);
    send_bit(w, 1'b0, 1'b0, e);
    for (int i = 0; i < 8; i++) send_bit(w, d[i], 1'b0, e);
    if (pen) send_bit(w, pbit, 1'b0, e);
    if (nstop == 2) begin
      send_bit(w, s1, 1'b0, e);
      send_bit(w, s2, 1'b1, e);
    end else begin
      send_bit(w, s1, 1'b1, e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    exp_t none;
    none = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("reset P_DATA", 32'(pd0), 32'h0);
    chk("reset busy", 32'(busy0), 32'h0);
    chk("reset err_cnt", 32'(ec0), 32'h0);
    chk("reset pulses", 32'({dv0, pe0, se0, sg0}), 32'h0);

    // 8N1 0xA5 good frame.
    PAR_EN = 1'b0;
    frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk(1, 0, 0, 0, 8'hA5));
    chk("8N1 busy after frame", 32'(busy0), 32'h0);
    chk("8N1 err_cnt", 32'(ec0), 32'd0);

    // 8E1 0xA5 with parity bit 1 (expected 0).
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    frame(0, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 1, mk(0, 1, 0, 0, 8'hA5));
    chk("8E1 par_err err_cnt", 32'(ec0), 32'd1);

    // 8O1 0x3C with correct parity 1.
    PAR_TYP = 1'b1;
    frame(0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1, mk(1, 0, 0, 0, 8'h3C));
    chk("8O1 good err_cnt", 32'(ec0), 32'd1);

    // 8N1 0x12 with stop bit 0.
    PAR_EN = 1'b0;
    frame(0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1, mk(0, 0, 1, 0, 8'h3C));
    chk("stop err err_cnt", 32'(ec0), 32'd2);

    // Config change after the start bit must be ignored: frame stays 8N1.
    PAR_EN = 1'b0; PAR_TYP = 1'b0;
    d = 8'h5A;
    send_bit(0, 1'b0, 1'b0, none);
    PAR_EN = 1'b1; PAR_TYP = 1'b1;
    chk("busy mid frame", 32'(busy0), 32'h1);
    for (int i = 0; i < 8; i++) send_bit(0, d[i], 1'b0, none);
    send_bit(0, 1'b1, 1'b1, mk(1, 0, 0, 0, 8'h5A));
    chk("cfg ignored busy", 32'(busy0), 32'h0);

    // Start glitch.
    send_bit(0, 1'b1, 1'b1, mk(0, 0, 0, 1, 8'h5A));
    chk("glitch busy", 32'(busy0), 32'h0);
    chk("glitch err_cnt", 32'(ec0), 32'd3);

    // 8E1 0x77 (even parity 0) sent with parity 1 and stop 0: one error.
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    frame(0, 8'h77, 1'b1, 1'b1, 1'b0, 1'b1, 1, mk(0, 1, 1, 0, 8'h5A));
    chk("both errors count once", 32'(ec0), 32'd4);

    // err_clr in the same cycle as a glitch increment.
    @(negedge CLK);
    q0.push_back('{dv: 1'b0, pe: 1'b0, se: 1'b0, sg: 1'b1, pd: 8'h5A, cyc: cyc + 1});
    sb0 = 1'b1; bv0 = 1'b1; err_clr = 1'b1;
    @(negedge CLK);
    bv0 = 1'b0; err_clr = 1'b0;
    chk("err_clr priority", 32'(ec0), 32'd0);

    // Saturation.
    for (int i = 0; i < 300; i++) send_bit(0, 1'b1, 1'b1, mk(0, 0, 0, 1, 8'h5A));
    chk("err_cnt saturates", 32'(ec0), 32'd255);
    @(negedge CLK); err_clr = 1'b1;
    @(negedge CLK); err_clr = 1'b0;
    chk("err_clr alone", 32'(ec0), 32'd0);

    // Reset after 4 data bits, then a clean 0x3C frame.
    PAR_EN = 1'b0;
    d = 8'h3C;
    send_bit(0, 1'b0, 1'b0, none);
    for (int i = 0; i < 4; i++) send_bit(0, d[i], 1'b0, none);
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);
    chk("mid reset busy", 32'(busy0), 32'h0);
    chk("mid reset P_DATA", 32'(pd0), 32'h0);
    frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1, mk(1, 0, 0, 0, 8'h3C));
    chk("post reset err_cnt", 32'(ec0), 32'd0);

    // Two stop bits.
    PAR_EN = 1'b0;
    frame(1, 8'h81, 1'b0, 1'b0, 1'b1, 1'b1, 2, mk(1, 0, 0, 0, 8'h81));
    frame(1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0, 2, mk(0, 0, 1, 0, 8'h81));
    chk("2stop second bad err_cnt", 32'(ec1), 32'd1);
    frame(1, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1, 2, mk(0, 0, 1, 0, 8'h81));
    chk("2stop first bad err_cnt", 32'(ec1), 32'd2);
    chk("2stop busy", 32'(busy1), 32'h0);

    repeat (4) @(negedge CLK);
    chk("dut0 queue drained", 32'(q0.size()), 32'd0);
    chk("dut1 queue drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_check.md
UART_RX_FRAME_CHECK -- requirements
Module: uart_rx_frame_check

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving data bits per frame (legal 5..9).
REQ-002 The block SHALL have parameter STOP_BITS, default 1, giving stop bits per frame (legal 1 or 2).
REQ-003 The block SHALL have parameter ERR_CNT_W, default 8, giving the error-counter width.
REQ-004 The block SHALL have port CLK, input, 1, the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port RST, input, 1, synchronous active-high reset.
REQ-006 The block SHALL have port sampled_bit, input, 1, the majority-voted bit from the sampler.
REQ-007 The block SHALL have port bit_valid, input, 1, a one-cycle strobe that qualifies sampled_bit; the first strobe in IDLE is the start-bit sample.
REQ-008 The block SHALL have port PAR_EN, input, 1, enabling the parity bit.
REQ-009 The block SHALL have port PAR_TYP, input, 1, selecting parity: 0 even, 1 odd.
REQ-010 The block SHALL have port err_clr, input, 1, clearing the error counter.
REQ-011 The block SHALL have port P_DATA, output, DATA_WIDTH, the last good received word.
REQ-012 The block SHALL have port data_valid, output, 1, a one-cycle pulse on a good frame.
REQ-013 The block SHALL have port strt_glitch, output, 1, a one-cycle pulse on a rejected start bit.
REQ-014 The block SHALL have ports par_err and stp_err, output, 1 each, one-cycle pulses on a parity or stop failure.
REQ-015 The block SHALL have port busy, output, 1, high while a frame is in progress.
REQ-016 The block SHALL have port err_cnt, output, ERR_CNT_W, the saturating count of errored frames.

Function
REQ-017 The FSM SHALL have states IDLE, DATA, PARITY, STOP; all outputs SHALL be registered.
REQ-018 In IDLE, on bit_valid with sampled_bit=0: SHALL latch PAR_EN/PAR_TYP, clear the bit counter, set busy, and go to DATA.
REQ-019 In IDLE, on bit_valid with sampled_bit=1: SHALL pulse strt_glitch the next cycle and remain in IDLE.
REQ-020 DATA SHALL shift bits LSB-first on each bit_valid; after DATA_WIDTH strobes it SHALL go to PARITY if latched PAR_EN=1, else to STOP.
REQ-021 PARITY SHALL compare the sampled bit with XOR(data) for even, or its inverse for odd; a mismatch SHALL set an internal parity-fail flag.
REQ-022 STOP SHALL consume STOP_BITS strobes; any sampled 0 SHALL set an internal stop-fail flag, and the remaining stop strobes SHALL still be consumed.
REQ-023 On the last stop strobe the FSM SHALL return to IDLE, and the next cycle: busy=0; the per-flag pulses par_err/stp_err; data_valid=1 with P_DATA updated only if both flags are clear.
REQ-024 P_DATA SHALL hold its value between good frames and SHALL NOT change on errored frames.
REQ-025 Cycles without bit_valid SHALL not advance state; config input changes mid-frame SHALL be ignored.
REQ-026 err_cnt SHALL increment by 1 per strt_glitch event and per errored frame (par_err or stp_err; both in one frame count as 1).
REQ-027 err_cnt SHALL saturate at all-ones.
REQ-028 err_clr SHALL force err_cnt to 0 and SHALL take priority over a simultaneous increment.
REQ-029 Latency from the final frame strobe to data_valid/error pulse SHALL be exactly 1 cycle.

Reset
REQ-030 RST=1 at a clock edge SHALL force IDLE, P_DATA=0, all pulses 0, busy=0, err_cnt=0, and internal flags and counters to 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no pulse; the next start strobe SHALL begin a fresh frame.

Verification
REQ-032 8N1, bits 0,0x A5 LSB-first, 1 -> data_valid one cycle, P_DATA=0xA5, err_cnt=0.
REQ-033 8E1, 0x A5 with parity bit 1 (expected 0) -> par_err pulse, no data_valid, P_DATA unchanged, err_cnt=1.
REQ-034 STOP_BITS=2, second stop sampled 0 -> stp_err after the second stop strobe only, err_cnt+1.
REQ-035 IDLE strobe with sampled_bit=1 -> strt_glitch one cycle, busy stays 0; 300 glitches with ERR_CNT_W=8 -> err_cnt=255.
REQ-036 err_clr asserted in the same cycle as an error increment -> err_cnt=0.
REQ-037 RST after 4 data bits, then a full good frame 0x3C -> data_valid once, P_DATA=0x3C.
